// File: rtl/retospect_bitstream_loader_if.sv
// rtl/retospect_bitstream_loader_if.sv - host word port of the config-chain loader
interface retospect_bitstream_loader_if #(
    parameter int WORD_W = 8
) ();
    logic              wr_valid;
    logic [WORD_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_valid;
    logic [WORD_W-1:0] rd_data;

    modport master (output wr_valid, wr_data, input wr_ready, rd_valid, rd_data);
    modport slave  (input wr_valid, wr_data, output wr_ready, rd_valid, rd_data);
endinterface

// File: rtl/retospect_bitstream_loader.sv
// rtl/retospect_bitstream_loader.sv - serialises host words into the config chain and captures readback
module retospect_bitstream_loader #(
    parameter int CHAIN_LEN    = 998,
    parameter int WORD_W       = 8,
    parameter int NNRST_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    retospect_bitstream_loader_if.slave  host,
    output logic                         config_en,
    output logic                         bs_out,
    input  logic                         bs_ret,
    output logic                         reset_nn,
    output logic                         busy,
    output logic                         done
);
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int NN_W  = (NNRST_CYCLES > 1) ? $clog2(NNRST_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, LOAD_WAIT, SHIFT, NNRST, FIN} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  bit_cnt, cnt_n;
    logic [IDX_W-1:0]  bit_idx, idx_n;
    logic [WORD_W-1:0] sh, sh_n;
    logic [WORD_W-1:0] rb, rb_n;
    logic [NN_W-1:0]   nn_cnt, nn_n;
    logic              bs_n, rd_valid_n;
    logic              wr_ready_q, rd_valid_q;

    assign host.wr_ready = wr_ready_q;
    assign host.rd_valid = rd_valid_q;
    assign host.rd_data  = rb;

    always_comb begin
        state_n    = state;
        cnt_n      = bit_cnt;
        idx_n      = bit_idx;
        sh_n       = sh;
        rb_n       = rb;
        nn_n       = nn_cnt;
        rd_valid_n = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = LOAD_WAIT;
                    cnt_n   = '0;
                end
            end
            LOAD_WAIT: begin
                if (host.wr_valid && wr_ready_q) begin
                    state_n = SHIFT;
                    sh_n    = host.wr_data;
                    idx_n   = '0;
                end
            end
            SHIFT: begin
                sh_n  = sh >> 1;
                idx_n = bit_idx + IDX_W'(1);
                cnt_n = bit_cnt + CNT_W'(1);
                // bs_ret is the tail bit before this cycle's shift; first bit of a word starts a fresh readback word
                rb_n = (bit_idx == '0) ? '0 : rb;
                rb_n[bit_idx] = bs_ret;
                if (bit_cnt == CNT_W'(CHAIN_LEN - 1)) begin
                    state_n    = NNRST;
                    nn_n       = '0;
                    rd_valid_n = 1'b1;
                end else if (bit_idx == IDX_W'(WORD_W - 1)) begin
                    state_n    = LOAD_WAIT;
                    rd_valid_n = 1'b1;
                end
            end
            NNRST: begin
                if (nn_cnt == NN_W'(NNRST_CYCLES - 1)) state_n = FIN;
                else nn_n = nn_cnt + NN_W'(1);
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (abort) begin
            state_n    = IDLE;
            rd_valid_n = 1'b0;
        end
        bs_n = (state_n == SHIFT) ? sh_n[0] : 1'b0;
    end

    // All outputs are flopped from the next state so nothing reaches the chain combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            sh         <= '0;
            rb         <= '0;
            nn_cnt     <= '0;
            config_en  <= 1'b0;
            bs_out     <= 1'b0;
            reset_nn   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wr_ready_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= cnt_n;
            bit_idx    <= idx_n;
            sh         <= sh_n;
            rb         <= rb_n;
            nn_cnt     <= nn_n;
            config_en  <= (state_n == SHIFT);
            bs_out     <= bs_n;
            reset_nn   <= (state_n == NNRST);
            busy       <= (state_n != IDLE);
            done       <= (state_n == FIN);
            wr_ready_q <= (state_n == LOAD_WAIT);
            rd_valid_q <= rd_valid_n;
        end
    end
endmodule
